activation_window: RTL and testbench
====================================

# activation_window

Sliding-window activation producer for the conv net. Accepts a stream of packed D-element activation vectors and presents the four time-ordered taps (oldest to newest, with optional dilation) that a 4-tap 1D convolution layer consumes. It sits upstream of each conv layer, between the previous layer's output (or the audio-input front end) and the conv block. It implements the producing side of the layer's packed-activation interface, with a valid/ready handshake on both sides.

## Interface

Parameters:
- W, 16, bits per element (signed, Q4.12 activations)
- D, 8, elements per packed vector
- DILATION, 1, sample spacing between taps (1..8); DEPTH = 3*DILATION+1 stored vectors

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of history and fill count
- in_v  in  1  input vector valid
- in_data  in  D*W  packed input vector, element 0 in MSBs
- in_ready  out  1  block can accept in_data this cycle
- out_v  out  1  window valid
- out_ready  in  1  downstream accepts window this cycle
- packed_a0  out  D*W  tap 0, oldest sample (entry 3*DILATION)
- packed_a1  out  D*W  tap 1 (entry 2*DILATION)
- packed_a2  out  D*W  tap 2 (entry DILATION)
- packed_a3  out  D*W  tap 3, newest sample (entry 0)
- fill_count  out  $clog2(DEPTH+1)  vectors held, saturating at DEPTH

## Operation

- History: DEPTH entries of D*W bits. Entry 0 is the newest. A push shifts entries k to k+1, drops entry DEPTH-1, and writes in_data to entry 0.
- Push condition: in_v && in_ready && !flush.
- in_ready = !out_v || out_ready. This is combinational, with no dependency on in_v.
- Two states:
  - FILL: out_v=0. A push increments fill_count. When a push makes fill_count == DEPTH, go to VALID.
  - VALID: out_v=1. Taps are driven straight from the history entries and stay stable while out_v && !out_ready.
    - out_ready with no push: go to FILL with fill_count held at DEPTH. The next push re-enters VALID.
    - out_ready with a push in the same cycle: stay in VALID. The new window is presented next cycle.
- Once full, the block delivers one window per accepted input. Windows overlap: consecutive windows share 3 taps for DILATION=1.
- The block is pure data movement: no arithmetic, and sign bits pass through untouched.
- flush takes priority over a push and over out_ready. On the next edge, all entries become 0, fill_count becomes 0, the state becomes FILL and out_v becomes 0. A vector presented during flush is dropped, even though in_ready may be high.
- Reset mid-operation: same effect as flush, applied asynchronously.

## Timing

- Reset values: out_v=0, fill_count=0, all packed_a* = 0, in_ready=1.
- Latency: out_v rises on the edge that accepts the DEPTH-th vector. Taps reflect that vector in the same cycle out_v is high.
- Throughput: 1 vector/cycle in, 1 window/cycle out when out_ready is held high.
- Backpressure: while out_v && !out_ready, in_ready=0. History, taps and fill_count are frozen.
- fill_count saturates at DEPTH and never wraps.
- No combinational path from in_data to the packed_a* outputs.

## Structure

- Shared package net_pkg holds W, D, and the state encoding constants FILL and VALID. The conv layers and the other window producers use the same package.
- One sub-module, sample_delay_line: a parameterised DEPTH x (D*W) shift register with shift enable and synchronous clear, exposing all entries.
- The top level holds the FSM, fill counter, handshake logic and tap selection.

## Test plan

- **Reset/fill, DILATION=1:** after rst, push vectors with all elements = 1, 2, 3 → out_v stays 0 and fill_count reads 1, 2, 3. Push 4 → same edge out_v=1; a0..a3 elements = 1, 2, 3, 4.
- **Streaming, out_ready held high:** push 5, 6, 7 on consecutive cycles → windows (2,3,4,5), (3,4,5,6), (4,5,6,7) on consecutive cycles; in_ready stays high throughout.
- **Backpressure:** window (1,2,3,4) is valid and out_ready=0 for 3 cycles while in_v=1 with value 9 → in_ready=0 and taps are unchanged for those cycles. Raise out_ready → 9 is accepted the same cycle and window (2,3,4,9) appears next cycle.
- **Dilation, DILATION=2 (DEPTH=7):** push 1..7 → out_v rises on the 7th push; a0..a3 = 1, 3, 5, 7. Push 8 → window 2, 4, 6, 8.
- **Flush with in_v high and a window pending:** taps are 0 the next cycle, out_v=0, fill_count=0 and the flushed-cycle vector is absent. The refill needs DEPTH fresh pushes.
- **Async reset mid-stream:** assert rst between edges → out_v, fill_count and taps go to 0 immediately. After release, behaviour matches the first scenario, including negative elements (0x8000) passing through unchanged.

Source files
------------

// File: rtl/net_pkg.sv
// Shared definitions for the conv net datapath: activation element format
// and the window-producer state encoding.
package net_pkg;

  localparam int W = 16;
  localparam int D = 8;

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } state_t;

endpackage

// File: rtl/sample_delay_line.sv
// DEPTH x WIDTH shift register with shift enable and synchronous clear.
// Entry 0 holds the newest sample; every entry is exposed.
module sample_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shift,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] entries
);

  // Clear wins over shift so a flushed cycle never leaves a stale sample behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else if (clear) begin
      entries <= '0;
    end else if (shift) begin
      entries <= {entries[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/activation_window.sv
// Sliding-window activation producer: presents four dilated, time-ordered
// taps of the incoming vector stream to a 4-tap 1D conv layer.
module activation_window #(
  parameter int W        = net_pkg::W,
  parameter int D        = net_pkg::D,
  parameter int DILATION = 1,
  localparam int DEPTH   = 3*DILATION+1,
  localparam int CW      = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_v,
  input  logic [D*W-1:0] in_data,
  output logic           in_ready,
  output logic           out_v,
  input  logic           out_ready,
  output logic [D*W-1:0] packed_a0,
  output logic [D*W-1:0] packed_a1,
  output logic [D*W-1:0] packed_a2,
  output logic [D*W-1:0] packed_a3,
  output logic [CW-1:0]  fill_count
);

  import net_pkg::*;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH-1);

  state_t                      state;
  logic                        push;
  logic [DEPTH-1:0][D*W-1:0]   entries;

  assign in_ready = !out_v || out_ready;
  assign push     = in_v && in_ready && !flush;

  sample_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (D*W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .shift   (push),
    .din     (in_data),
    .entries (entries)
  );

  assign packed_a0 = entries[3*DILATION];
  assign packed_a1 = entries[2*DILATION];
  assign packed_a2 = entries[DILATION];
  assign packed_a3 = entries[0];

  // Once full, the count parks at DEPTH so a drained window is re-armed by a single push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      out_v      <= 1'b0;
      fill_count <= '0;
    end else if (flush) begin
      state      <= FILL;
      out_v      <= 1'b0;
      fill_count <= '0;
    end else begin
      if (push && fill_count != DEPTH_C) begin
        fill_count <= fill_count + CW'(1);
      end
      case (state)
        FILL: begin
          if (push && fill_count >= LAST_C) begin
            state <= VALID;
            out_v <= 1'b1;
          end
        end
        VALID: begin
          if (out_ready && !push) begin
            state <= FILL;
            out_v <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_window.sv
// Directed bench for activation_window: DILATION=1 and DILATION=2 instances
// driven with hand-computed vectors and expected windows.
module tb_activation_window;

  localparam int VW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          d1_flush = 1'b0, d1_in_v = 1'b0, d1_out_ready = 1'b0;
  logic [VW-1:0] d1_in_data = '0;
  logic          d1_in_ready, d1_out_v;
  logic [VW-1:0] d1_a0, d1_a1, d1_a2, d1_a3;
  logic [2:0]    d1_fill;

  logic          d2_flush = 1'b0, d2_in_v = 1'b0, d2_out_ready = 1'b1;
  logic [VW-1:0] d2_in_data = '0;
  logic          d2_in_ready, d2_out_v;
  logic [VW-1:0] d2_a0, d2_a1, d2_a2, d2_a3;
  logic [2:0]    d2_fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activation_window #(.DILATION(1)) dut1 (
    .clk(clk), .rst(rst), .flush(d1_flush), .in_v(d1_in_v), .in_data(d1_in_data),
    .in_ready(d1_in_ready), .out_v(d1_out_v), .out_ready(d1_out_ready),
    .packed_a0(d1_a0), .packed_a1(d1_a1), .packed_a2(d1_a2), .packed_a3(d1_a3),
    .fill_count(d1_fill)
  );

  activation_window #(.DILATION(2)) dut2 (
    .clk(clk), .rst(rst), .flush(d2_flush), .in_v(d2_in_v), .in_data(d2_in_data),
    .in_ready(d2_in_ready), .out_v(d2_out_v), .out_ready(d2_out_ready),
    .packed_a0(d2_a0), .packed_a1(d2_a1), .packed_a2(d2_a2), .packed_a3(d2_a3),
    .fill_count(d2_fill)
  );

  function automatic logic [VW-1:0] vec(input logic [15:0] e);
    vec = {8{e}};
  endfunction

  task automatic checkOutput(input string tag, input logic [VW-1:0] actual,
                             input logic [VW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkWindow1(input string tag, input logic [VW-1:0] e0, input logic [VW-1:0] e1,
                              input logic [VW-1:0] e2, input logic [VW-1:0] e3);
    checkOutput({tag, " out_v"}, VW'(d1_out_v), VW'(1));
    checkOutput({tag, " a0"}, d1_a0, e0);
    checkOutput({tag, " a1"}, d1_a1, e1);
    checkOutput({tag, " a2"}, d1_a2, e2);
    checkOutput({tag, " a3"}, d1_a3, e3);
  endtask

  // Drives one instance's inputs and advances to just after the next rising edge.
  task automatic applyStimulus(input bit sel, input logic v, input logic [VW-1:0] data,
                               input logic rdy, input logic fl);
    if (!sel) begin
      d1_in_v = v; d1_in_data = data; d1_out_ready = rdy; d1_flush = fl;
    end else begin
      d2_in_v = v; d2_in_data = data; d2_out_ready = rdy; d2_flush = fl;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] mixed;
    mixed = {4{16'h8000, 16'hFFFF}};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_v", VW'(d1_out_v), VW'(0));
    checkOutput("reset fill", VW'(d1_fill), VW'(0));
    checkOutput("reset a0", d1_a0, '0);
    checkOutput("reset a3", d1_a3, '0);
    checkOutput("reset in_ready", VW'(d1_in_ready), VW'(1));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] fill, DILATION=1");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1'b1, vec(16'(i)), 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d out_v", i), VW'(d1_out_v), VW'(0));
      checkOutput($sformatf("fill%0d count", i), VW'(d1_fill), VW'(i));
    end
    applyStimulus(0, 1'b1, vec(16'd4), 1'b0, 1'b0);
    checkWindow1("first window", vec(1), vec(2), vec(3), vec(4));
    checkOutput("full count", VW'(d1_fill), VW'(4));

    $display("[TB] streaming");
    for (int i = 5; i <= 7; i++) begin
      d1_in_v = 1'b1; d1_in_data = vec(16'(i)); d1_out_ready = 1'b1;
      #1;
      checkOutput($sformatf("stream%0d in_ready", i), VW'(d1_in_ready), VW'(1));
      applyStimulus(0, 1'b1, vec(16'(i)), 1'b1, 1'b0);
      checkWindow1($sformatf("stream%0d", i), vec(16'(i-3)), vec(16'(i-2)),
                   vec(16'(i-1)), vec(16'(i)));
    end
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("drained out_v", VW'(d1_out_v), VW'(0));
    checkOutput("drained count", VW'(d1_fill), VW'(4));
    applyStimulus(0, 1'b1, vec(16'd8), 1'b0, 1'b0);
    checkWindow1("rearm", vec(5), vec(6), vec(7), vec(8));

    $display("[TB] flush with window pending");
    applyStimulus(0, 1'b1, vec(16'h0055), 1'b1, 1'b1);
    checkOutput("flush out_v", VW'(d1_out_v), VW'(0));
    checkOutput("flush count", VW'(d1_fill), VW'(0));
    checkOutput("flush a0", d1_a0, '0);
    checkOutput("flush a3", d1_a3, '0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1'b1, vec(16'(i)), 1'b0, 1'b0);
    checkOutput("refill3 out_v", VW'(d1_out_v), VW'(0));
    checkOutput("refill3 count", VW'(d1_fill), VW'(3));
    checkOutput("refill3 a0", d1_a0, '0);
    checkOutput("refill3 a3", d1_a3, vec(3));
    applyStimulus(0, 1'b1, vec(16'd4), 1'b0, 1'b0);
    checkWindow1("refill window", vec(1), vec(2), vec(3), vec(4));

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, vec(16'd9), 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d in_ready", i), VW'(d1_in_ready), VW'(0));
      checkWindow1($sformatf("stall%0d", i), vec(1), vec(2), vec(3), vec(4));
      checkOutput($sformatf("stall%0d count", i), VW'(d1_fill), VW'(4));
    end
    d1_out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", VW'(d1_in_ready), VW'(1));
    applyStimulus(0, 1'b1, vec(16'd9), 1'b1, 1'b0);
    checkWindow1("after stall", vec(2), vec(3), vec(4), vec(9));
    applyStimulus(0, 1'b1, vec(16'd10), 1'b1, 1'b0);
    checkWindow1("after stall next", vec(3), vec(4), vec(9), vec(10));

    $display("[TB] async reset mid-stream");
    d1_in_v = 1'b0;
    #2;
    rst = 1'b1;
    #2;
    checkOutput("async out_v", VW'(d1_out_v), VW'(0));
    checkOutput("async count", VW'(d1_fill), VW'(0));
    checkOutput("async a0", d1_a0, '0);
    checkOutput("async a3", d1_a3, '0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, vec(16'd1), 1'b0, 1'b0);
    checkOutput("post1 count", VW'(d1_fill), VW'(1));
    applyStimulus(0, 1'b1, mixed, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, vec(16'd3), 1'b0, 1'b0);
    checkOutput("post3 out_v", VW'(d1_out_v), VW'(0));
    checkOutput("post3 count", VW'(d1_fill), VW'(3));
    applyStimulus(0, 1'b1, vec(16'd4), 1'b0, 1'b0);
    checkWindow1("signed window", vec(1), mixed, vec(3), vec(4));
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] dilation 2");
    for (int i = 1; i <= 6; i++) applyStimulus(1, 1'b1, vec(16'(i)), 1'b1, 1'b0);
    checkOutput("dil6 out_v", VW'(d2_out_v), VW'(0));
    checkOutput("dil6 count", VW'(d2_fill), VW'(6));
    applyStimulus(1, 1'b1, vec(16'd7), 1'b1, 1'b0);
    checkOutput("dil7 out_v", VW'(d2_out_v), VW'(1));
    checkOutput("dil7 count", VW'(d2_fill), VW'(7));
    checkOutput("dil7 a0", d2_a0, vec(1));
    checkOutput("dil7 a1", d2_a1, vec(3));
    checkOutput("dil7 a2", d2_a2, vec(5));
    checkOutput("dil7 a3", d2_a3, vec(7));
    applyStimulus(1, 1'b1, vec(16'd8), 1'b1, 1'b0);
    checkOutput("dil8 out_v", VW'(d2_out_v), VW'(1));
    checkOutput("dil8 count", VW'(d2_fill), VW'(7));
    checkOutput("dil8 a0", d2_a0, vec(2));
    checkOutput("dil8 a1", d2_a1, vec(4));
    checkOutput("dil8 a2", d2_a2, vec(6));
    checkOutput("dil8 a3", d2_a3, vec(8));
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
